// File: rtl/seq_multiplier_4bit.sv
// Sequential 4x4 unsigned shift-and-add multiplier with a ripple-carry
// four_bit_adder supplying each partial-product sum.

module four_bit_adder (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] S,
    output logic       Cout
);
    logic [4:0] carry;

    assign carry[0] = Cin;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_bit
            assign S[gi]       = A[gi] ^ B[gi] ^ carry[gi];
            assign carry[gi+1] = (A[gi] & B[gi]) | (carry[gi] & (A[gi] ^ B[gi]));
        end
    endgenerate

    assign Cout = carry[4];
endmodule

module seq_multiplier_4bit (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       busy,
    output logic       done,
    output logic [7:0] product
);
    typedef enum logic {IDLE = 1'b0, CALC = 1'b1} state_t;

    state_t     state_reg, state_next;
    logic [3:0] m_reg, m_next;
    logic [3:0] acc_reg, acc_next;
    logic [3:0] q_reg, q_next;
    logic [2:0] cnt_reg, cnt_next;
    logic       busy_reg, busy_next;
    logic       done_reg, done_next;
    logic [7:0] product_reg, product_next;

    logic [3:0] add_s;
    logic       add_cout;
    logic [4:0] sum;

    four_bit_adder u_adder (
        .A    (acc_reg),
        .B    (m_reg),
        .Cin  (1'b0),
        .S    (add_s),
        .Cout (add_cout)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (cnt_reg == 3'd3) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath and output next values; the full 5-bit sum feeds the shift
    always_comb begin
        sum          = q_reg[0] ? {add_cout, add_s} : {1'b0, acc_reg};
        m_next       = m_reg;
        acc_next     = acc_reg;
        q_next       = q_reg;
        cnt_next     = cnt_reg;
        done_next    = 1'b0;
        product_next = product_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    m_next   = a;
                    q_next   = b;
                    acc_next = 4'd0;
                    cnt_next = 3'd0;
                end
            end
            CALC: begin
                acc_next = sum[4:1];
                q_next   = {sum[0], q_reg[3:1]};
                cnt_next = cnt_reg + 3'd1;
                if (cnt_reg == 3'd3) begin
                    product_next = {sum[4:1], sum[0], q_reg[3:1]};
                    done_next    = 1'b1;
                end
            end
            default: ;
        endcase
        busy_next = (state_next == CALC);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_reg       <= 4'd0;
            acc_reg     <= 4'd0;
            q_reg       <= 4'd0;
            cnt_reg     <= 3'd0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            product_reg <= 8'h00;
        end else begin
            m_reg       <= m_next;
            acc_reg     <= acc_next;
            q_reg       <= q_next;
            cnt_reg     <= cnt_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
            product_reg <= product_next;
        end
    end

    assign busy    = busy_reg;
    assign done    = done_reg;
    assign product = product_reg;
endmodule

// File: tb/tb_seq_multiplier_4bit.sv
// Self-checking bench for seq_multiplier_4bit: table-driven operations with a
// product scoreboard, plus hand-written busy-start, back-to-back and reset sequences.

module tb_seq_multiplier_4bit;
    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [7:0] product;

    int n_cmp = 0;
    int n_err = 0;
    int done_count = 0;
    logic [7:0] sb[$];

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[8];

    seq_multiplier_4bit dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest expected product
    always @(negedge clk) begin
        if (!rst) begin
            check("busy_done_exclusive", {31'd0, busy & done}, 32'd0);
            if (done) begin
                done_count++;
                if (sb.size() == 0) begin
                    check("unexpected_done", {24'd0, product}, 32'hFFFF_FFFF);
                end else begin
                    logic [7:0] e;
                    e = sb.pop_front();
                    check("product_at_done", {24'd0, product}, {24'd0, e});
                    $display("txn: product=%0d expected=%0d", product, e);
                end
            end
        end
    end

    task automatic run_op(input logic [3:0] va, input logic [3:0] vb, input logic [7:0] exp);
        @(posedge clk); #1;
        start = 1'b1; a = va; b = vb;
        sb.push_back(exp);
        @(posedge clk); #1;                 // E0
        start = 1'b0; a = 4'($urandom); b = 4'($urandom);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("busy_during_calc", {31'd0, busy}, 32'd1);
            check("no_early_done", {31'd0, done}, 32'd0);
        end
        @(negedge clk);                     // after E4
        check("done_after_e4", {31'd0, done}, 32'd1);
        check("busy_low_at_done", {31'd0, busy}, 32'd0);
        @(negedge clk);                     // after E5
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("product_holds", {24'd0, product}, {24'd0, exp});
    endtask

    initial begin
        int dc;
        rst = 1'b1; start = 1'b0; a = 4'd0; b = 4'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_product", {24'd0, product}, 32'd0);
        #1 rst = 1'b0;

        // 5*6 with product retention
        run_op(4'd5, 4'd6, 8'h1E);
        repeat (2) @(negedge clk);
        check("product_retained", {24'd0, product}, 32'h1E);

        vecs[0] = '{4'd9,  4'd7,  8'h3F};
        vecs[1] = '{4'd15, 4'd15, 8'hE1};
        vecs[2] = '{4'd0,  4'd13, 8'h00};
        vecs[3] = '{4'd11, 4'd0,  8'h00};
        vecs[4] = '{4'd1,  4'd1,  8'h01};
        vecs[5] = '{4'd8,  4'd15, 8'h78};
        vecs[6] = '{4'd15, 4'd1,  8'h0F};
        vecs[7] = '{4'd13, 4'd11, 8'h8F};
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].exp);
        end
        for (int i = 0; i < 4; i++) begin
            logic [3:0] ra, rb;
            ra = 4'($urandom); rb = 4'($urandom);
            run_op(ra, rb, 8'(ra) * 8'(rb));
        end

        // start while busy is ignored
        dc = done_count;
        @(posedge clk); #1;
        start = 1'b1; a = 4'd3; b = 4'd4;
        sb.push_back(8'h0C);
        @(posedge clk); #1;                 // E0
        start = 1'b0;
        @(posedge clk); @(posedge clk); #1; // after E2
        start = 1'b1; a = 4'd15; b = 4'd15;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (14) @(negedge clk);
        check("single_done_when_busy_start", done_count - dc, 32'd1);

        // start held high: one result per 5 clocks
        @(posedge clk); #1;
        start = 1'b1; a = 4'd12; b = 4'd10;
        repeat (3) sb.push_back(8'h78);
        dc = done_count;
        @(posedge clk);                     // E0
        for (int k = 0; k < 15; k++) begin
            if (k == 10) begin
                #1 start = 1'b0;
            end
            @(negedge clk);
            check("held_done", {31'd0, done}, {31'd0, (k % 5) == 4});
            check("held_busy", {31'd0, busy}, {31'd0, (k % 5) != 4});
            @(posedge clk);
        end
        @(negedge clk);
        check("held_done_count", done_count - dc, 32'd3);
        check("held_idle_after", {31'd0, busy}, 32'd0);

        // reset mid-operation
        run_op(4'd5, 4'd6, 8'h1E);
        dc = done_count;
        @(posedge clk); #1;
        start = 1'b1; a = 4'd9; b = 4'd9;
        @(posedge clk); #1;                 // E0
        start = 1'b0;
        @(posedge clk); #1;                 // E1
        rst = 1'b1;
        @(posedge clk); #1;                 // E2 applies reset
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_product", {24'd0, product}, 32'd0);
        repeat (8) @(negedge clk);
        check("abort_no_done", done_count - dc, 32'd0);
        run_op(4'd2, 4'd3, 8'h06);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
